// File: rtl/fabric_port_pkg.sv
// Shared types and helpers for the fabric port arbiters.
package fabric_port_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Widest flit the tail helper accepts; callers zero-extend into it.
  localparam int unsigned MAX_FLIT_W = 64;

  // Width of a channel index / rr pointer for n channels (at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when the flit carries the end-of-packet marker.
  function automatic logic is_tail(input logic [MAX_FLIT_W-1:0] flit,
                                   input logic [5:0]            tail_pos);
    return flit[tail_pos];
  endfunction

endpackage

// File: rtl/fabric_port_out_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr, wrapping.
module rr_arbiter
  import fabric_port_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned RR_W   = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [RR_W-1:0]   rr,
  output logic [NUM_CH-1:0] grant,
  output logic              any_req
);

  int unsigned     cand;
  logic [RR_W-1:0] idx;

  // Walk channels rr, rr+1, ... with explicit modulo wrap so odd NUM_CH works.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    cand    = 0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = 32'(rr) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      idx = RR_W'(cand);
      if (!any_req && req[idx]) begin
        grant[idx] = 1'b1;
        any_req    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fabric_port_out_arbiter.sv
// Packet-level round-robin arbiter feeding the output-port demux through a
// one-entry registered show-ahead buffer; a grant is held until its tail flit.
module fabric_port_out_arbiter
  import fabric_port_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TAIL_POS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] i_data,
  input  logic [NUM_CH-1:0]       i_empty,
  output logic [NUM_CH-1:0]       o_read_en,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_empty,
  input  logic                    i_read_en
);

  localparam int unsigned RR_W = idx_width(NUM_CH);

  arb_state_t              state_q, state_d;
  logic [RR_W-1:0]         rr_q, rr_d;
  logic [RR_W-1:0]         g_q, g_d;
  logic                    valid_q, valid_d;
  logic [WIDTH-1:0]        data_q, data_d;

  logic [NUM_CH-1:0]       arb_grant;
  logic                    arb_any;
  logic [RR_W-1:0]         grant_idx;
  logic [WIDTH-1:0]        g_flit;
  logic                    g_empty;
  logic                    can_load;
  logic                    pop;
  logic [MAX_FLIT_W-1:0]   flit_ext;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .RR_W   (RR_W)
  ) u_rr (
    .req     (~i_empty),
    .rr      (rr_q),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  assign can_load = ~valid_q | i_read_en;
  assign o_data   = data_q;
  assign o_empty  = ~valid_q;

  // Select the granted channel's flit/empty and encode the arbiter's one-hot pick.
  always_comb begin
    g_flit    = '0;
    g_empty   = 1'b1;
    grant_idx = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (g_q == RR_W'(c)) begin
        g_flit  = i_data[c*WIDTH +: WIDTH];
        g_empty = i_empty[c];
      end
      if (arb_grant[c]) grant_idx = RR_W'(c);
    end
  end

  // Next-state, pop strobe and output-buffer update.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    g_d       = g_q;
    valid_d   = valid_q;
    data_d    = data_q;
    o_read_en = '0;
    pop       = 1'b0;
    flit_ext  = '0;
    flit_ext[WIDTH-1:0] = g_flit;

    // A read drains the buffer; a pop below overrides this with the new flit.
    if (valid_q && i_read_en) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          g_d     = grant_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        pop = can_load & ~g_empty;
        if (pop) begin
          o_read_en[g_q] = 1'b1;
          data_d         = g_flit;
          valid_d        = 1'b1;
          if (is_tail(flit_ext, 6'(TAIL_POS))) begin
            state_d = IDLE;
            rr_d    = (g_q == RR_W'(NUM_CH - 1)) ? '0 : g_q + RR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant, rr pointer and output buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_fabric_port_out_arbiter.sv
// Randomized + directed bench for fabric_port_out_arbiter. Upstream FIFOs are
// modelled as queues; expected output order is computed at packet level.
module tb_fabric_port_out_arbiter;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned WIDTH    = 4;
  localparam int unsigned TAIL_POS = 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH*WIDTH-1:0] i_data;
  logic [NUM_CH-1:0]       i_empty;
  logic [NUM_CH-1:0]       o_read_en;
  logic [WIDTH-1:0]        o_data;
  logic                    o_empty;
  logic                    i_read_en;

  fabric_port_out_arbiter #(
    .NUM_CH   (NUM_CH),
    .WIDTH    (WIDTH),
    .TAIL_POS (TAIL_POS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_data    (i_data),
    .i_empty   (i_empty),
    .o_read_en (o_read_en),
    .o_data    (o_data),
    .o_empty   (o_empty),
    .i_read_en (i_read_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] chq [NUM_CH][$];
  logic [WIDTH-1:0] tq  [NUM_CH][$];
  logic [WIDTH-1:0] exp_q[$];
  bit               at_head [NUM_CH];
  int               pop_cnt [NUM_CH];
  logic [NUM_CH-1:0] stall;

  int          cyc = 0;
  int          deliv_cnt = 0;
  int          first_valid = -1;
  int          last_deliv = -1;
  int          gap_exp = 0;
  bit          gap_chk = 0;
  bit          block_ch0 = 0;
  bit          stall_en = 0;
  bit          prev_hold = 0;
  int          rd_mode = 0;
  int unsigned m_rr = 0;
  logic [WIDTH-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit tb_tail(input logic [WIDTH-1:0] f);
    return f[TAIL_POS];
  endfunction

  function automatic logic [WIDTH-1:0] mk_flit(input bit tail);
    logic [WIDTH-1:0] f;
    f = WIDTH'($urandom);
    f[TAIL_POS] = tail;
    return f;
  endfunction

  task automatic load_pkt(input int c, input int len);
    for (int i = 0; i < len; i++) chq[c].push_back(mk_flit(i == len - 1));
  endtask

  // Present queue fronts; stalls only hide mid-packet flits so packet order is unaffected.
  task automatic drive_inputs();
    for (int c = 0; c < NUM_CH; c++) begin
      stall[c]   = stall_en && ($urandom_range(0, 2) == 0);
      i_empty[c] = (chq[c].size() == 0) || (stall[c] && !at_head[c]);
      i_data[c*WIDTH +: WIDTH] = (chq[c].size() != 0) ? chq[c][0] : '0;
    end
    case (rd_mode)
      0:       i_read_en = 1'b1;
      1:       i_read_en = 1'($urandom_range(0, 1));
      default: i_read_en = 1'b0;
    endcase
  endtask

  // Packet-level round robin over the current queue contents.
  task automatic build_exp();
    bit               found;
    int unsigned      c;
    logic [WIDTH-1:0] f;
    for (int i = 0; i < NUM_CH; i++) tq[i] = chq[i];
    forever begin
      found = 0;
      c     = 0;
      for (int unsigned k = 0; k < NUM_CH; k++)
        if (!found && tq[(m_rr + k) % NUM_CH].size() != 0) begin
          found = 1;
          c     = (m_rr + k) % NUM_CH;
        end
      if (!found) break;
      do begin
        f = tq[c].pop_front();
        exp_q.push_back(f);
      end while (!tb_tail(f) && tq[c].size() != 0);
      m_rr = (c + 1) % NUM_CH;
    end
  endtask

  // One clock: sample at negedge, then apply pops and new inputs just after posedge.
  task automatic step();
    logic [NUM_CH-1:0] rd;
    logic [WIDTH-1:0]  e;
    @(negedge clk);
    rd = o_read_en;
    check("rd_onehot", 32'($countones(rd) <= 1), 32'd1);
    check("pop_from_empty", 32'(rd & i_empty), 32'd0);
    if (rd != 0) check("pop_overflow", 32'(!o_empty && !i_read_en), 32'd0);
    if (block_ch0) check("ch0_blocked", 32'(rd[0]), 32'd0);
    if (prev_hold) begin
      check("hold_valid", 32'(o_empty), 32'd0);
      check("hold_data", 32'(o_data), 32'(prev_data));
    end
    if (!o_empty && first_valid < 0) first_valid = cyc;
    if (i_read_en && !o_empty) begin
      deliv_cnt++;
      check("flit_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("flit_data", 32'(o_data), 32'(e));
      end
      if (gap_chk && last_deliv >= 0) check("deliv_gap", 32'(cyc - last_deliv), 32'(gap_exp));
      last_deliv = cyc;
    end
    prev_hold = !o_empty && !i_read_en;
    prev_data = o_data;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < NUM_CH; c++)
      if (rd[c]) begin
        if (chq[c].size() != 0) begin
          at_head[c] = tb_tail(chq[c][0]);
          void'(chq[c].pop_front());
        end
        pop_cnt[c]++;
      end
    drive_inputs();
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n = 0;
    int total = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done"}, 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    for (int c = 0; c < NUM_CH; c++) total += chq[c].size();
    check({tag, "_drained"}, 32'(total), 32'd0);
  endtask

  // Asynchronous reset: outputs are checked before any clock edge occurs.
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_read_en", 32'(o_read_en), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    exp_q.delete();
    prev_hold   = 0;
    m_rr        = 0;
    first_valid = -1;
    last_deliv  = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    drive_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: still running at %0t, expected finish well before", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base0, base2, d0, load_cyc;
    rst_n     = 1'b1;
    i_read_en = 1'b0;
    i_empty   = '1;
    i_data    = '0;
    stall     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      at_head[c] = 1;
      pop_cnt[c] = 0;
    end
    #1;
    do_reset();

    // Single 4-flit packet on ch0: two-cycle latency, one flit per cycle.
    rd_mode = 0; gap_chk = 1; gap_exp = 1; last_deliv = -1; first_valid = -1;
    chq[0].push_back(4'h1); chq[0].push_back(4'h4);
    chq[0].push_back(4'h9); chq[0].push_back(4'hE);
    build_exp();
    load_cyc = cyc;
    drive_inputs();
    run_until_done(40, "s1");
    check("s1_latency", 32'(first_valid - load_cyc), 32'd2);
    check("s1_pops", 32'(pop_cnt[0]), 32'd4);
    gap_chk = 0;

    // ch1 and ch3 contend; no interleaving, rr order.
    chq[1].push_back(4'h5); chq[1].push_back(4'h6);
    chq[3].push_back(4'h8); chq[3].push_back(4'hB);
    build_exp();
    drive_inputs();
    run_until_done(40, "s2");
    check("s2_pops_ch1", 32'(pop_cnt[1]), 32'd2);
    check("s2_pops_ch3", 32'(pop_cnt[3]), 32'd2);

    // Backpressure: demux not reading, only one flit may enter the buffer.
    rd_mode = 2;
    base2 = pop_cnt[2];
    chq[2].push_back(4'hC); chq[2].push_back(4'h1);
    chq[2].push_back(4'h5); chq[2].push_back(4'h7);
    build_exp();
    drive_inputs();
    repeat (8) step();
    check("s3_one_pop", 32'(pop_cnt[2] - base2), 32'd1);
    check("s3_valid", 32'(o_empty), 32'd0);
    check("s3_data", 32'(o_data), 32'hC);
    rd_mode = 0;
    drive_inputs();
    run_until_done(40, "s3");

    // ch2 runs dry mid-packet while ch0 waits; grant must stay on ch2.
    base2 = pop_cnt[2];
    chq[2].push_back(4'h9); chq[2].push_back(4'hD);
    exp_q.push_back(4'h9); exp_q.push_back(4'hD);
    drive_inputs();
    n = 0;
    while (pop_cnt[2] - base2 < 2 && n < 20) begin step(); n++; end
    check("s4_first_half", 32'(pop_cnt[2] - base2), 32'd2);
    base0 = pop_cnt[0];
    chq[0].push_back(4'h4); chq[0].push_back(4'h2);
    block_ch0 = 1;
    drive_inputs();
    repeat (6) step();
    check("s4_ch0_wait", 32'(pop_cnt[0] - base0), 32'd0);
    chq[2].push_back(4'h0); chq[2].push_back(4'hA);
    exp_q.push_back(4'h0); exp_q.push_back(4'hA);
    exp_q.push_back(4'h4); exp_q.push_back(4'h2);
    drive_inputs();
    n = 0;
    while (pop_cnt[2] - base2 < 4 && n < 20) begin step(); n++; end
    block_ch0 = 0;
    run_until_done(40, "s4");
    check("s4_ch0_pops", 32'(pop_cnt[0] - base0), 32'd2);
    m_rr = 1;

    // Single-flit packets everywhere from a fresh reset: order 0,1,2,3,0, one bubble each.
    #2;
    do_reset();
    rd_mode = 0; gap_chk = 1; gap_exp = 2; last_deliv = -1;
    load_pkt(0, 1); load_pkt(0, 1);
    load_pkt(1, 1); load_pkt(2, 1); load_pkt(3, 1);
    build_exp();
    drive_inputs();
    run_until_done(60, "s5");
    gap_chk = 0;

    // Reset mid-packet on ch1; arbitration restarts from ch0 afterwards.
    chq[1].push_back(4'h1); chq[1].push_back(4'h4);
    chq[1].push_back(4'h5); chq[1].push_back(4'hE);
    exp_q.push_back(4'h1); exp_q.push_back(4'h4);
    exp_q.push_back(4'h5); exp_q.push_back(4'hE);
    drive_inputs();
    d0 = deliv_cnt;
    n = 0;
    while (deliv_cnt - d0 < 2 && n < 20) begin step(); n++; end
    check("s6_two_sent", 32'(deliv_cnt - d0), 32'd2);
    chq[0].push_back(4'h8); chq[0].push_back(4'h3);
    chq[2].push_back(4'hC); chq[2].push_back(4'hF);
    drive_inputs();
    #2;
    do_reset();
    check("s6_ch1_left", 32'(chq[1].size()), 32'd1);
    build_exp();
    check("s6_first_exp", 32'(exp_q[0]), 32'h8);
    run_until_done(60, "s6");

    // Random packets, random demux reads, random mid-packet FIFO gaps.
    stall_en = 1;
    for (int r = 0; r < 8; r++) begin
      rd_mode = $urandom_range(0, 1);
      for (int c = 0; c < NUM_CH; c++) begin
        n = $urandom_range(0, 2);
        for (int p = 0; p < n; p++) load_pkt(c, $urandom_range(1, 4));
      end
      build_exp();
      drive_inputs();
      run_until_done(800, "rand");
    end
    stall_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
